// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing back ends.
//   ST_IDLE / ST_WARMUP / ST_RUN / ST_DONE : 2-bit FSM state encoding
//   clog2_f                                : ceiling log2, usable in parameter expressions
package sc_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Smallest r with 2**r >= value. A fixed-bound loop keeps it elaboration friendly.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_ones_accum.sv
// Ones accumulator: counts the high bits of a serial stream.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count (wins over enable)
//   enable   : add bit_in to the count this cycle
//   bit_in   : serial stream bit
//   count    : running count, W bits unsigned
module sc_ones_accum #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         bit_in,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(bit_in);
        end
    end

endmodule

// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary back end: gates a circuit's run control, skips WARMUP
// start-up bits, counts ones over STREAM_LEN cycles and hands the count to the host.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle request to begin an evaluation
//   busy          : high in WARMUP and RUN
//   run_n         : circuit rst_n; 0 = circuit stepping, 1 = circuit held/cleared
//   bit_in        : circuit output stream
//   result        : count of ones, stable while result_valid is high
//   result_valid  : result available
//   result_ready  : host accepts result
//   state         : current FSM state (debug visibility)
// Handshake: the result transfers on a cycle where result_valid and result_ready
// are both high; until then result and result_valid hold indefinitely.
module sc_stream_counter
    import sc_pkg::*;
#(
    parameter int STREAM_LEN = 256,
    parameter int WARMUP     = 2,
    parameter int CNT_W      = clog2_f(STREAM_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             run_n,
    input  logic             bit_in,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [1:0]       state
);

    localparam int PH_W = clog2_f(STREAM_LEN);
    localparam logic [PH_W-1:0] RUN_LAST  = PH_W'(STREAM_LEN - 1);
    localparam logic [PH_W-1:0] WARM_LAST = PH_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    // With no warm-up an evaluation enters RUN directly.
    localparam logic [1:0] ST_FIRST = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] result_q;
    logic             last_run;
    logic             acc_clear;
    logic             consume;

    assign busy         = (state_q == ST_WARMUP) || (state_q == ST_RUN);
    assign run_n        = ~busy;
    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;
    assign state        = state_q;

    assign consume   = result_valid && result_ready;
    assign last_run  = (state_q == ST_RUN) && (phase == RUN_LAST);
    assign acc_clear = (state_d == ST_RUN) && (state_q != ST_RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FIRST;
            end
            ST_WARMUP: begin
                if (phase == WARM_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_run) state_d = ST_DONE;
            end
            ST_DONE: begin
                // start only counts here when it coincides with the consume.
                if (consume) state_d = start ? ST_FIRST : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            // One counter serves both phases: it restarts on every state change.
            if (state_d != state_q) begin
                phase <= '0;
            end else if (busy) begin
                phase <= phase + PH_W'(1);
            end
            // The final bit is still in flight, so fold it in while latching.
            if (last_run) begin
                result_q <= acc + CNT_W'(bit_in);
            end
        end
    end

    sc_ones_accum #(
        .W(CNT_W)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .enable (state_q == ST_RUN),
        .bit_in (bit_in),
        .count  (acc)
    );

endmodule
